// File: rtl/eeprom_i2c_master.sv
// Register-mapped I2C initiator for the serial EEPROM: START/STOP/byte commands
// paced by a quarter-period divider on clk_ce, with sticky status and a done pulse.
module eeprom_i2c_master #(
  parameter logic [23:0] REG_CTRL = 24'h2090,
  parameter logic [23:0] REG_DATA = 24'h2091,
  parameter logic [23:0] REG_STAT = 24'h2092,
  parameter int unsigned DIV      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic        bus_write,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        scl,
  output logic        sda_out,
  input  logic        sda_in,
  output logic        busy,
  output logic        irq_done
);

  typedef enum logic [2:0] {IDLE, START, STOP, XFER, ACK, DONE} state_t;
  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_START   = 3'd1,
    CMD_STOP    = 3'd2,
    CMD_WRITE   = 3'd3,
    CMD_RD_ACK  = 3'd4,
    CMD_RD_NACK = 3'd5
  } cmd_t;

  localparam logic [7:0] QLAST = 8'(DIV - 1);

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  qcnt_q, qcnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        ack_q, ack_d;
  logic        ovr_q, ovr_d;
  logic        done_q, done_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        enter;
  logic        wr_ctrl, wr_data, wr_stat, cmd_ok;

  assign wr_ctrl  = clk_ce && bus_write && (bus_address_in == REG_CTRL);
  assign wr_data  = clk_ce && bus_write && (bus_address_in == REG_DATA);
  assign wr_stat  = clk_ce && bus_write && (bus_address_in == REG_STAT);
  assign cmd_ok   = (bus_data_in[2:0] != 3'd0) && (bus_data_in[2:0] <= 3'd5);
  assign busy     = (state_q == START) || (state_q == STOP) || (state_q == XFER) || (state_q == ACK);
  assign irq_done = (state_q == DONE);
  assign scl      = scl_q;
  assign sda_out  = sda_q;

  always_comb begin
    if (bus_address_in == REG_DATA)      bus_data_out = data_q;
    else if (bus_address_in == REG_STAT) bus_data_out = {4'b0000, done_q, ovr_q, ack_q, busy};
    else                                 bus_data_out = '0;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    phase_d = phase_q;
    qcnt_d  = qcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ack_d   = ack_q;
    ovr_d   = ovr_q;
    done_d  = done_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    enter   = 1'b0;

    if (wr_stat) begin
      ovr_d  = 1'b0;
      done_d = 1'b0;
    end
    if (wr_ctrl && busy) ovr_d = 1'b1;
    if (wr_data) begin
      if (busy) ovr_d = 1'b1;
      else      data_d = bus_data_in;
    end

    if (clk_ce) begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (wr_ctrl && cmd_ok) begin
            cmd_d   = cmd_t'(bus_data_in[2:0]);
            phase_d = '0;
            qcnt_d  = '0;
            bit_d   = 3'd7;
            enter   = 1'b1;
            case (cmd_t'(bus_data_in[2:0]))
              CMD_START: state_d = START;
              CMD_STOP:  state_d = STOP;
              default:   state_d = XFER;
            endcase
          end
        end
        default: begin
          if (qcnt_q == QLAST) begin
            qcnt_d  = '0;
            phase_d = phase_q + 2'd1;
            enter   = 1'b1;
            if (phase_q == 2'd3) begin
              case (state_q)
                XFER: begin
                  shift_d = {shift_q[6:0], sda_in};
                  if (bit_q == 3'd0) state_d = ACK;
                  else               bit_d = bit_q - 3'd1;
                end
                ACK: begin
                  if (cmd_q == CMD_WRITE) ack_d  = sda_in;
                  else                    data_d = shift_q;
                  state_d = DONE;
                end
                default: state_d = DONE;
              endcase
            end
          end else begin
            qcnt_d = qcnt_q + 8'd1;
          end
        end
      endcase
    end

    // Line levels are registered at the first tick of each quarter, so they are
    // computed from the quarter being entered rather than the one being left.
    if (enter) begin
      case (state_d)
        START: case (phase_d)
          2'd0:    sda_d = 1'b1;
          2'd1:    scl_d = 1'b1;
          2'd2:    sda_d = 1'b0;
          default: scl_d = 1'b0;
        endcase
        STOP: case (phase_d)
          2'd0: begin
            scl_d = 1'b0;
            sda_d = 1'b0;
          end
          2'd1:    scl_d = 1'b1;
          2'd2:    sda_d = 1'b1;
          default: ;
        endcase
        XFER: case (phase_d)
          2'd0: begin
            scl_d = 1'b0;
            sda_d = (cmd_d == CMD_WRITE) ? data_q[bit_d] : 1'b1;
          end
          2'd2:    scl_d = 1'b1;
          default: ;
        endcase
        ACK: case (phase_d)
          2'd0: begin
            scl_d = 1'b0;
            sda_d = (cmd_d == CMD_RD_ACK) ? 1'b0 : 1'b1;
          end
          2'd2:    scl_d = 1'b1;
          default: ;
        endcase
        default: ;
      endcase
    end

    // Completion: done sticks even against a same-tick STAT clear.
    if (state_d == DONE && state_q != DONE) begin
      done_d = 1'b1;
      if (state_q == ACK) scl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NOP;
      phase_q <= '0;
      qcnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      phase_q <= phase_d;
      qcnt_q  <= qcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

endmodule

// File: tb/tb_eeprom_i2c_master.sv
// Scoreboard bench: commands push expected line activity; a bus monitor decodes
// scl/sda and compares on every completion pulse. A responder drives sda_in.
module tb_eeprom_i2c_master;

  localparam int unsigned DIV = 2;
  localparam logic [23:0] A_CTRL = 24'h2090;
  localparam logic [23:0] A_DATA = 24'h2091;
  localparam logic [23:0] A_STAT = 24'h2092;

  logic        clk = 1'b0;
  logic        reset, clk_ce, bus_write, sda_in;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in, bus_data_out;
  logic        scl, sda_out, busy, irq_done;

  eeprom_i2c_master #(
    .REG_CTRL(A_CTRL),
    .REG_DATA(A_DATA),
    .REG_STAT(A_STAT),
    .DIV(DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_ce(clk_ce),
    .bus_write(bus_write),
    .bus_address_in(bus_address_in),
    .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out),
    .scl(scl),
    .sda_out(sda_out),
    .sda_in(sda_in),
    .busy(busy),
    .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_byte;
    logic [8:0] bits;
    int         ticks;
    int         starts;
    int         stops;
    logic       end_scl;
    logic       end_sda;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   mon_done = 0, exp_done = 0;
  bit   ce_rand = 1'b1;
  logic [8:0] resp_vec = 9'h1FF;
  int   resp_gen = 0;
  logic [7:0] m_data;
  logic m_ack, m_ovr, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus_write = 1'b0;
    clk_ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_write = 1'b1;
    bus_address_in = a;
    bus_data_in = d;
    clk_ce = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [23:0] a, output logic [7:0] v);
    tick();
    bus_address_in = a;
    #1 v = bus_data_out;
  endtask

  task automatic check_regs(input string name);
    logic [7:0] v;
    rd(A_DATA, v);
    chk({name, "_data"}, v, m_data);
    rd(A_STAT, v);
    chk({name, "_stat"}, v, {4'b0000, m_done, m_ovr, m_ack, 1'b0});
  endtask

  // Issue a command and record what the serial line must show for it.
  task automatic issue(input int code, input logic [7:0] r, input logic a);
    exp_t e;
    e.is_byte = 1'b0;
    e.bits = '0;
    e.starts = 0;
    e.stops = 0;
    e.ticks = 36 * DIV;
    e.end_scl = 1'b0;
    e.end_sda = 1'b1;
    case (code)
      1: begin e.ticks = 4 * DIV; e.starts = 1; e.end_sda = 1'b0; end
      2: begin e.ticks = 4 * DIV; e.stops = 1; e.end_scl = 1'b1; end
      3: begin
        e.is_byte = 1'b1;
        e.bits = {m_data, 1'b1};
        m_ack = a;
        resp_vec = {8'($urandom), a};
      end
      default: begin
        e.is_byte = 1'b1;
        e.bits = {8'hFF, code == 5};
        e.end_sda = (code == 5);
        m_data = r;
        resp_vec = {r, 1'($urandom)};
      end
    endcase
    m_done = 1'b1;
    resp_gen++;
    exp_q.push_back(e);
    exp_done++;
    wr(A_CTRL, 8'(code));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_completed"}, n < 3000, 1);
  endtask

  // Responder: presents bit k of resp_vec while scl is low before the k-th rise.
  initial begin : responder
    int cnt, seen;
    logic ps;
    cnt = 0; seen = 0; ps = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (resp_gen != seen) begin seen = resp_gen; cnt = 0; end
      if (scl && !ps) cnt++;
      if (!scl && cnt <= 8) sda_in = resp_vec[8 - cnt];
      ps = scl;
    end
  end

  initial begin : monitor
    int tk, iw, nb, st, sp;
    logic [8:0] bits;
    logic scl_p, sda_p, busy_p, irq_p;
    exp_t e;
    tk = 0; iw = 0; nb = 0; st = 0; sp = 0; bits = '0;
    scl_p = 1'b1; sda_p = 1'b1; busy_p = 1'b0; irq_p = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        tk = 0; iw = 0; nb = 0; st = 0; sp = 0; bits = '0;
      end else begin
        if (clk_ce && busy_p) tk++;
        if (clk_ce && irq_p) iw++;
        if (scl && !scl_p) begin bits = {bits[7:0], sda_out}; nb++; end
        if (scl && scl_p && sda_p && !sda_out) st++;
        if (scl && scl_p && !sda_p && sda_out) sp++;
        if (irq_done && !irq_p) begin
          mon_done++;
          if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("busy_ticks", tk, e.ticks);
            chk("start_cond", st, e.starts);
            chk("stop_cond", sp, e.stops);
            chk("end_scl", scl, e.end_scl);
            chk("end_sda", sda_out, e.end_sda);
            if (e.is_byte) begin
              chk("bit_count", nb, 9);
              chk("line_bits", bits, e.bits);
            end
          end
          tk = 0; nb = 0; st = 0; sp = 0; bits = '0;
        end
        if (!irq_done && irq_p) begin
          chk("irq_width", iw, 1);
          iw = 0;
        end
      end
      scl_p = scl; sda_p = sda_out; busy_p = busy; irq_p = irq_done;
    end
  end

  initial begin : stimulus
    logic [7:0] v, d;
    logic [3:0] snap;
    bit changed;
    int code;
    reset = 1'b0; clk_ce = 1'b0; bus_write = 1'b0; bus_address_in = '0;
    bus_data_in = '0; sda_in = 1'b1;
    m_data = '0; m_ack = 1'b0; m_ovr = 1'b0; m_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("rst_lines", {scl, sda_out, busy, irq_done}, 4'b1100);
    rd(A_CTRL, v);
    chk("rst_ctrl_read", v, 0);
    check_regs("rst");

    issue(1, 0, 0); wait_done("start");
    check_regs("start");
    issue(2, 0, 0); wait_done("stop");
    chk("stop_lines", {scl, sda_out}, 2'b11);
    wr(A_STAT, 0); m_done = 1'b0; m_ovr = 1'b0;

    wr(A_DATA, 8'hA5); m_data = 8'hA5;
    issue(3, 0, 1'b0); wait_done("wr_a5_ack");
    check_regs("wr_a5_ack");
    issue(3, 0, 1'b1); wait_done("wr_a5_nack");
    check_regs("wr_a5_nack");
    issue(5, 8'h3C, 0); wait_done("rd_nack_3c");
    check_regs("rd_nack_3c");
    issue(4, 8'($urandom), 0); wait_done("rd_ack");
    check_regs("rd_ack");

    for (int i = 0; i < 12; i++) begin
      code = $urandom_range(1, 5);
      if (code == 3 && $urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        wr(A_DATA, d); m_data = d;
      end
      issue(code, 8'($urandom), 1'($urandom)); wait_done("rand_cmd");
      check_regs("rand_cmd");
      if ($urandom_range(0, 2) == 0) begin
        wr(A_STAT, 8'($urandom)); m_done = 1'b0; m_ovr = 1'b0;
      end
    end

    d = 8'($urandom);
    wr(A_DATA, d); m_data = d;
    issue(3, 0, 1'b0);
    repeat (5) tick();
    wr(A_CTRL, 8'd4); m_ovr = 1'b1;
    wr(A_DATA, ~d);
    wait_done("overrun");
    check_regs("overrun");
    chk("overrun_irq_count", mon_done, exp_done);
    wr(A_STAT, 0); m_ovr = 1'b0; m_done = 1'b0;
    check_regs("stat_clear");

    // STAT clear lands on the completion tick of a START (8th busy tick).
    ce_rand = 1'b0;
    issue(1, 0, 0);
    repeat (6) tick();
    wr(A_STAT, 0);
    wait_done("done_vs_clear");
    ce_rand = 1'b1;
    check_regs("done_vs_clear");

    rd(24'h2093, v); chk("iso_2093", v, 0);
    rd(A_CTRL, v);   chk("iso_ctrl", v, 0);

    d = 8'($urandom);
    wr(A_DATA, d); m_data = d;
    issue(3, 0, 1'($urandom));
    repeat (10) tick();
    @(negedge clk); clk_ce = 1'b0;
    #1 snap = {scl, sda_out, busy, irq_done};
    changed = 1'b0;
    repeat (100) begin
      @(negedge clk); clk_ce = 1'b0;
      if ({scl, sda_out, busy, irq_done} !== snap) changed = 1'b1;
    end
    chk("ce_hold_frozen", changed, 0);
    wait_done("ce_hold");
    check_regs("ce_hold");

    wr(A_DATA, 8'h5A); m_data = 8'h5A;
    issue(3, 0, 1'b0);
    repeat (20) tick();
    chk("busy_before_reset", busy, 1);
    #2 reset = 1'b0;
    #1 chk("async_reset_lines", {scl, sda_out, busy, irq_done}, 4'b1100);
    exp_q.delete(); exp_done--;
    m_data = '0; m_ack = 1'b0; m_ovr = 1'b0; m_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_regs("after_reset");
    issue(1, 0, 0); wait_done("post_reset_start");

    chk("completions", mon_done, exp_done);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
